// File: rtl/alu_arbiter_if.sv
// Signal bundle between two requesters, the alu_arbiter and the shared registered ALU.
// slave = arbiter side, master = requester/ALU side.
interface alu_arbiter_if #(
   parameter int NUMBITS = 32
);
   logic               req0_valid;
   logic               req0_ready;
   logic [NUMBITS-1:0] req0_a;
   logic [NUMBITS-1:0] req0_b;
   logic [2:0]         req0_op;

   logic               req1_valid;
   logic               req1_ready;
   logic [NUMBITS-1:0] req1_a;
   logic [NUMBITS-1:0] req1_b;
   logic [2:0]         req1_op;

   logic               resp0_valid;
   logic               resp0_ready;
   logic [NUMBITS-1:0] resp0_result;
   logic [2:0]         resp0_flags;

   logic               resp1_valid;
   logic               resp1_ready;
   logic [NUMBITS-1:0] resp1_result;
   logic [2:0]         resp1_flags;

   logic [NUMBITS-1:0] alu_a;
   logic [NUMBITS-1:0] alu_b;
   logic [2:0]         alu_opcode;
   logic [NUMBITS-1:0] alu_result;
   logic               alu_carryout;
   logic               alu_overflow;
   logic               alu_zero;

   logic               busy;

   modport slave (
      input  req0_valid, req0_a, req0_b, req0_op,
      input  req1_valid, req1_a, req1_b, req1_op,
      output req0_ready, req1_ready,
      output resp0_valid, resp0_result, resp0_flags,
      output resp1_valid, resp1_result, resp1_flags,
      input  resp0_ready, resp1_ready,
      output alu_a, alu_b, alu_opcode,
      input  alu_result, alu_carryout, alu_overflow, alu_zero,
      output busy
   );

   modport master (
      output req0_valid, req0_a, req0_b, req0_op,
      output req1_valid, req1_a, req1_b, req1_op,
      input  req0_ready, req1_ready,
      input  resp0_valid, resp0_result, resp0_flags,
      input  resp1_valid, resp1_result, resp1_flags,
      output resp0_ready, resp1_ready,
      input  alu_a, alu_b, alu_opcode,
      output alu_result, alu_carryout, alu_overflow, alu_zero,
      input  busy
   );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared registered ALU; one operation in flight.
// ALU_ARB_FIXED_PRI_EN selects fixed priority (requester 0 wins); otherwise round-robin.
module alu_arbiter #(
   parameter int NUMBITS = 32
) (
   input  logic         clk,
   input  logic         reset,
   alu_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t             state_reg;
   state_t             state_next;
   logic               grant_reg;
   logic               pick;
   logic               load_en;
   logic [1:0]         req_valid;
   logic [1:0]         req_ready;
   logic [1:0]         resp_ready;
   logic [NUMBITS-1:0] alu_a_reg;
   logic [NUMBITS-1:0] alu_b_reg;
   logic [2:0]         alu_opcode_reg;
   logic [2:0]         alu_flags;

   assign req_valid  = {bus.req1_valid, bus.req0_valid};
   assign resp_ready = {bus.resp1_ready, bus.resp0_ready};
   assign alu_flags  = {bus.alu_carryout, bus.alu_overflow, bus.alu_zero};

`ifdef ALU_ARB_FIXED_PRI_EN
   assign pick = ~req_valid[0];
`else
   logic last_grant_reg;

   // On contention the requester not served last wins; a lone requester always wins.
   assign pick = (&req_valid) ? ~last_grant_reg : req_valid[1];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_grant_reg <= 1'b1;
      end else if (load_en) begin
         last_grant_reg <= pick;
      end
   end
`endif

   always_comb begin
      state_next = state_reg;
      load_en    = 1'b0;
      req_ready  = 2'b00;
      case (state_reg)
         IDLE: begin
            // Ready is gated by reset so it reads 0 while reset is held.
            if (reset && (|req_valid)) begin
               req_ready  = pick ? 2'b10 : 2'b01;
               load_en    = 1'b1;
               state_next = ISSUE;
            end
         end
         ISSUE: state_next = WAIT;
         WAIT:  state_next = RESP;
         RESP: begin
            if (resp_ready[grant_reg]) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg      <= IDLE;
         grant_reg      <= 1'b0;
         alu_a_reg      <= '0;
         alu_b_reg      <= '0;
         alu_opcode_reg <= '0;
      end else begin
         state_reg <= state_next;
         if (load_en) begin
            grant_reg      <= pick;
            alu_a_reg      <= pick ? bus.req1_a  : bus.req0_a;
            alu_b_reg      <= pick ? bus.req1_b  : bus.req0_b;
            alu_opcode_reg <= pick ? bus.req1_op : bus.req0_op;
         end
      end
   end

   // Per-requester response holding registers; only the granted one is ever written.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_resp
         localparam logic SEL = 1'(gi);
         logic [NUMBITS-1:0] result_reg;
         logic [2:0]         flags_reg;
         logic               valid;

         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               result_reg <= '0;
               flags_reg  <= '0;
            end else if ((state_reg == WAIT) && (grant_reg == SEL)) begin
               result_reg <= bus.alu_result;
               flags_reg  <= alu_flags;
            end
         end

         assign valid = (state_reg == RESP) && (grant_reg == SEL);
      end
   endgenerate

   assign bus.req0_ready   = req_ready[0];
   assign bus.req1_ready   = req_ready[1];
   assign bus.resp0_valid  = g_resp[0].valid;
   assign bus.resp0_result = g_resp[0].result_reg;
   assign bus.resp0_flags  = g_resp[0].flags_reg;
   assign bus.resp1_valid  = g_resp[1].valid;
   assign bus.resp1_result = g_resp[1].result_reg;
   assign bus.resp1_flags  = g_resp[1].flags_reg;
   assign bus.alu_a        = alu_a_reg;
   assign bus.alu_b        = alu_b_reg;
   assign bus.alu_opcode   = alu_opcode_reg;
   assign bus.busy         = (state_reg != IDLE);

   a_ready_onehot: assert property (@(posedge clk) disable iff (!reset)
      !(&req_ready));
   a_ready_only_idle: assert property (@(posedge clk) disable iff (!reset)
      (state_reg != IDLE) |-> (req_ready == 2'b00));

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural registered ALU on the shared port.
// Expectations follow ALU_ARB_FIXED_PRI_EN when the bench is built with it.
module tb_alu_arbiter;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad   = 0;

`ifdef ALU_ARB_FIXED_PRI_EN
   localparam bit RR = 1'b0;
`else
   localparam bit RR = 1'b1;
`endif

   alu_arbiter_if #(.NUMBITS(32)) bus ();

   alu_arbiter #(.NUMBITS(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Shared ALU: flags packed as {carry/borrow, signed overflow, zero}.
   function automatic logic [34:0] alu_f(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [32:0] w;
      logic [31:0] r;
      logic        c;
      logic        v;
      w = '0; r = '0; c = 1'b0; v = 1'b0;
      case (op)
         3'd0, 3'd1: begin
            w = {1'b0, a} + {1'b0, b};
            r = w[31:0];
            c = w[32];
            if (op == 3'd1) v = (a[31] == b[31]) && (r[31] != a[31]);
         end
         3'd2, 3'd3: begin
            r = a - b;
            c = (a < b);
            if (op == 3'd3) v = (a[31] != b[31]) && (r[31] != a[31]);
         end
         3'd4: r = a & b;
         3'd5: r = a | b;
         3'd6: r = a ^ b;
         default: r = a >> 1;
      endcase
      return {c, v, (r == 32'd0), r};
   endfunction

   always @(posedge clk) begin
      {bus.alu_carryout, bus.alu_overflow, bus.alu_zero, bus.alu_result} <=
         alu_f(bus.alu_opcode, bus.alu_a, bus.alu_b);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end else begin
         $display("ok   %s: %0h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One isolated request from requester idx, checked end to end with resp ready held high.
   task automatic do_op(input bit idx, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic [2:0] ef, input string tag);
      int n;
      bus.resp0_ready = 1'b1;
      bus.resp1_ready = 1'b1;
      if (!idx) begin
         bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
      end else begin
         bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
      end
      #1;
      n = 0;
      while (((idx ? bus.req1_ready : bus.req0_ready) !== 1'b1) && (n < 8)) begin
         tick();
         n++;
      end
      check({tag, "_rdy"}, idx ? bus.req1_ready : bus.req0_ready, 1);
      tick();
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      check({tag, "_aluop"}, bus.alu_opcode, op);
      check({tag, "_alua"}, bus.alu_a, a);
      check({tag, "_alub"}, bus.alu_b, b);
      n = 0;
      while (((idx ? bus.resp1_valid : bus.resp0_valid) !== 1'b1) && (n < 8)) begin
         tick();
         n++;
      end
      check({tag, "_lat"}, n, 2);
      check({tag, "_res"}, idx ? bus.resp1_result : bus.resp0_result, er);
      check({tag, "_flg"}, idx ? bus.resp1_flags : bus.resp0_flags, ef);
      check({tag, "_other"}, idx ? bus.resp0_valid : bus.resp1_valid, 0);
      tick();
      check({tag, "_idle"}, bus.busy, 0);
   endtask

   initial begin
      int cnt;
      reset = 1'b0;
      bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0;
      bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0;
      bus.resp0_ready = 1'b0; bus.resp1_ready = 1'b0;
      tick();
      tick();

      // Reset state, with a request already pending.
      bus.req0_valid = 1'b1; bus.req0_op = 3'd0; bus.req0_a = 32'd5; bus.req0_b = 32'd7;
      bus.resp0_ready = 1'b1; bus.resp1_ready = 1'b1;
      #1;
      check("rst_busy", bus.busy, 0);
      check("rst_rdy0", bus.req0_ready, 0);
      check("rst_resp0v", bus.resp0_valid, 0);
      check("rst_alua", bus.alu_a, 0);
      check("rst_res0", bus.resp0_result, 0);

      // Simple add: 5 + 7, transfer in the cycle reset is released.
      reset = 1'b1;
      #1;
      check("add_rdy0", bus.req0_ready, 1);
      tick();
      bus.req0_valid = 1'b0;
      check("add_busy", bus.busy, 1);
      check("add_alua", bus.alu_a, 5);
      check("add_alub", bus.alu_b, 7);
      check("add_rdy_after", bus.req0_ready, 0);
      tick();
      check("add_v_early", bus.resp0_valid, 0);
      tick();
      check("add_v", bus.resp0_valid, 1);
      check("add_res", bus.resp0_result, 12);
      check("add_flg", bus.resp0_flags, 3'b000);
      check("add_v1", bus.resp1_valid, 0);
      tick();
      check("add_done", bus.resp0_valid, 0);
      check("add_idle", bus.busy, 0);

      // Contention after reset: signed-add overflow from both requesters.
      reset = 1'b0;
      tick();
      reset = 1'b1;
      bus.req0_valid = 1'b1; bus.req0_op = 3'd1; bus.req0_a = 32'h7FFF_FFFF; bus.req0_b = 32'd1;
      bus.req1_valid = 1'b1; bus.req1_op = 3'd1; bus.req1_a = 32'h7FFF_FFFF; bus.req1_b = 32'd1;
      #1;
      for (int k = 0; k < 3; k++) begin
         bit w;
         w = RR && (k == 1);
         check($sformatf("arb%0d_rdy0", k), bus.req0_ready, !w);
         check($sformatf("arb%0d_rdy1", k), bus.req1_ready, w);
         tick();
         if (k == 2) begin
            bus.req0_valid = 1'b0;
            bus.req1_valid = 1'b0;
         end
         check($sformatf("arb%0d_rdy_busy", k), {bus.req1_ready, bus.req0_ready}, 2'b00);
         tick();
         tick();
         check($sformatf("arb%0d_v0", k), bus.resp0_valid, !w);
         check($sformatf("arb%0d_v1", k), bus.resp1_valid, w);
         check($sformatf("arb%0d_res", k), w ? bus.resp1_result : bus.resp0_result, 32'h8000_0000);
         check($sformatf("arb%0d_flg", k), w ? bus.resp1_flags : bus.resp0_flags, 3'b010);
         tick();
         check($sformatf("arb%0d_idle", k), bus.busy, 0);
      end

      // Sub to zero on requester 1 with a stalled response; requester 0 waits meanwhile.
      bus.resp1_ready = 1'b0;
      bus.req1_valid = 1'b1; bus.req1_op = 3'd2; bus.req1_a = 32'd5; bus.req1_b = 32'd5;
      #1;
      check("stall_rdy1", bus.req1_ready, 1);
      tick();
      bus.req1_valid = 1'b0;
      bus.req0_valid = 1'b1; bus.req0_op = 3'd0; bus.req0_a = 32'd1; bus.req0_b = 32'd2;
      #1;
      check("stall_rdy0_issue", bus.req0_ready, 0);
      tick();
      check("stall_rdy0_wait", bus.req0_ready, 0);
      tick();
      for (int i = 0; i < 4; i++) begin
         check($sformatf("stall%0d_v1", i), bus.resp1_valid, 1);
         check($sformatf("stall%0d_res", i), bus.resp1_result, 0);
         check($sformatf("stall%0d_flg", i), bus.resp1_flags, 3'b001);
         check($sformatf("stall%0d_rdy0", i), bus.req0_ready, 0);
         tick();
      end
      check("stall_res0_kept", bus.resp0_result, 32'h8000_0000);
      check("stall_v0", bus.resp0_valid, 0);
      bus.resp1_ready = 1'b1;
      #1;
      check("stall_v1_last", bus.resp1_valid, 1);
      tick();
      check("lone_rdy0", bus.req0_ready, 1);

      // Reset while requester 0's operation sits in WAIT.
      tick();
      bus.req0_valid = 1'b0;
      tick();
      check("mid_busy_pre", bus.busy, 1);
      reset = 1'b0;
      bus.req0_valid = 1'b1;
      bus.req1_valid = 1'b1;
      #1;
      check("mid_busy", bus.busy, 0);
      check("mid_v0", bus.resp0_valid, 0);
      check("mid_res0", bus.resp0_result, 0);
      check("mid_flg1", bus.resp1_flags, 0);
      check("mid_alua", bus.alu_a, 0);
      check("mid_alub", bus.alu_b, 0);
      check("mid_aluop", bus.alu_opcode, 0);
      check("mid_rdy", {bus.req1_ready, bus.req0_ready}, 2'b00);
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      cnt = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (bus.resp0_valid === 1'b1 || bus.busy === 1'b1) cnt++;
      end
      check("mid_no_resp", cnt, 0);

      // Remaining opcodes and edge values, alternating requesters.
      do_op(1'b0, 3'd6, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FF00, 3'b000, "xor0");
      do_op(1'b1, 3'd3, 32'h8000_0000, 32'd1,         32'h7FFF_FFFF, 3'b010, "ssub1");
      do_op(1'b0, 3'd4, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 3'b000, "and0");
      do_op(1'b1, 3'd5, 32'd0,         32'd0,         32'd0,         3'b001, "or1");
      do_op(1'b0, 3'd7, 32'd3,         32'd0,         32'd1,         3'b000, "shr0");
      do_op(1'b1, 3'd0, 32'hFFFF_FFFF, 32'd1,         32'd0,         3'b101, "add1");
      do_op(1'b0, 3'd2, 32'd3,         32'd5,         32'hFFFF_FFFE, 3'b100, "sub0");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
